instr_store: RTL

Parametrised instruction memory for the execution engine. It holds `DEPTH` opcodes of `OPCODE_W` bits and serves registered single-cycle fetches addressed by the program pointer. It adds three things the fixed 10×26 store lacks:
- a valid/ready program-load port with an auto-incrementing write address;
- a bounded, one-address-per-cycle clear sequence after reset;
- an out-of-range fetch error.

---
 rtl/instr_pkg.sv | 12 +
 rtl/instr_store_if.sv | 34 +++
 rtl/instr_store_ctrl.sv | 116 +++++++++++
 rtl/instr_store.sv | 82 ++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared types and defaults for the instruction store and its sequencer.
package instr_pkg;

   localparam int OPCODE_W_DEF = 26;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2
   } store_state_t;

endpackage

// File: rtl/instr_store_if.sv
// Fetch and program-load bus of the instruction store; master drives requests, slave is the store.
interface instr_store_if
   import instr_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int ADDR_W   = 4
);

   logic                fetch_en;
   logic [ADDR_W-1:0]   prog_pointer;
   logic [OPCODE_W-1:0] opcode;
   logic                opcode_valid;
   logic                addr_err;
   logic                load_start;
   logic [ADDR_W-1:0]   load_base;
   logic                load_valid;
   logic                load_last;
   logic [OPCODE_W-1:0] load_data;
   logic                load_ready;
   logic                load_done;
   logic [ADDR_W:0]     load_count;
   logic                busy;

   modport master (
      output fetch_en, prog_pointer, load_start, load_base, load_valid, load_last, load_data,
      input  opcode, opcode_valid, addr_err, load_ready, load_done, load_count, busy
   );

   modport slave (
      input  fetch_en, prog_pointer, load_start, load_base, load_valid, load_last, load_data,
      output opcode, opcode_valid, addr_err, load_ready, load_done, load_count, busy
   );

endinterface

// File: rtl/instr_store_ctrl.sv
// Store sequencer: post-reset clear, program load with auto-increment, write-port steering.
// Write port acts in the same cycle as the state; load_ready comes straight from the state register.
module instr_store_ctrl
   import instr_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_start,
   input  logic [ADDR_W-1:0]   load_base,
   input  logic                load_valid,
   input  logic                load_last,
   input  logic [OPCODE_W-1:0] load_data,
   output logic                load_ready,
   output logic                load_done,
   output logic [ADDR_W:0]     load_count,
   output logic                base_err,
   output logic                idle,
   output logic                busy,
   output logic                we,
   output logic [ADDR_W-1:0]   waddr,
   output logic [OPCODE_W-1:0] wdata
);

   localparam int                AW1       = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W   = AW1'(DEPTH);

   store_state_t      state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              we_raw;
   logic              base_ok;

   assign base_ok = {1'b0, load_base} < DEPTH_W;

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      we_raw  = 1'b0;
      waddr   = clr_q;
      wdata   = '0;
      case (state_q)
         CLEAR: begin
            we_raw = 1'b1;
            clr_d  = clr_q + 1'b1;
            if (clr_q == LAST_ADDR) state_d = IDLE;
         end
         IDLE: begin
            if (load_start) begin
               cnt_d = '0;
               if (base_ok) begin
                  state_d = LOAD;
                  wr_d    = load_base;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (load_valid) begin
               we_raw = 1'b1;
               waddr  = wr_q;
               wdata  = load_data;
               wr_d   = wr_q + 1'b1;
               cnt_d  = cnt_q + 1'b1;
               // The top slot ends a load even without load_last: no wrap-around.
               if (load_last || wr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         clr_q   <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // A word presented on the reset edge must not land in the array.
   assign we         = we_raw & ~reset;
   assign load_ready = (state_q == LOAD);
   assign idle       = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign load_done  = done_q;
   assign load_count = cnt_q;
   assign base_err   = err_q;

endmodule

// File: rtl/instr_store.sv
// Instruction memory: registered fetch (1-cycle latency, 1/cycle) by prog_pointer, out-of-range flagged.
// Fetches only honoured in IDLE; loads accepted one word per cycle via load_valid/load_ready.
module instr_store
   import instr_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       reset,
   instr_store_if.slave bus
);

   localparam int              AW1     = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH_W = AW1'(DEPTH);

   logic [OPCODE_W-1:0] mem [DEPTH];
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [OPCODE_W-1:0] wdata;
   logic                idle;
   logic                base_err;
   logic                ptr_ok;
   logic [OPCODE_W-1:0] opcode_q;
   logic                valid_q;
   logic                fetch_err_q;

   instr_store_ctrl #(
      .OPCODE_W (OPCODE_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .load_start (bus.load_start),
      .load_base  (bus.load_base),
      .load_valid (bus.load_valid),
      .load_last  (bus.load_last),
      .load_data  (bus.load_data),
      .load_ready (bus.load_ready),
      .load_done  (bus.load_done),
      .load_count (bus.load_count),
      .base_err   (base_err),
      .idle       (idle),
      .busy       (bus.busy),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata)
   );

   assign ptr_ok = {1'b0, bus.prog_pointer} < DEPTH_W;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opcode_q    <= '0;
         valid_q     <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         fetch_err_q <= 1'b0;
         if (idle && bus.fetch_en) begin
            valid_q <= 1'b1;
            if (ptr_ok) begin
               opcode_q <= mem[bus.prog_pointer];
            end else begin
               opcode_q    <= '0;
               fetch_err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.opcode       = opcode_q;
   assign bus.opcode_valid = valid_q;
   assign bus.addr_err     = fetch_err_q | base_err;

endmodule
